reg_file_np: RTL and testbench

- Parametrised successor to the fixed 8x10 tri-state register file, with one write port and two independent read ports.
- Width and depth are configurable; read outputs are registered and individually enabled.
- Optional write-to-read bypass, optional hardwired-zero R0, per-register valid tracking, and a multi-cycle sweep-clear engine with a BUSY flag.
- Sits in the datapath as the general-purpose register bank feeding the ALU operand buses.

---
 rtl/reg_file_np.sv | 129 ++++++++++++
 tb/tb_reg_file_np.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_np.sv
// rtl/reg_file_np.sv - parametrised 1W/2R register file with bypass, zero-R0, valid bits and sweep-clear
// Registered read ports; a CLR pulse starts a DEPTH-cycle sweep that zeroes one entry per edge.
module reg_file_np #(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 8,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic [WIDTH-1:0] D,
  input  logic             ENW,
  input  logic [AW-1:0]    WRA,
  input  logic             ENR0,
  input  logic [AW-1:0]    RDA0,
  input  logic             ENR1,
  input  logic [AW-1:0]    RDA1,
  input  logic             CLR,
  output logic             BUSY,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             VAL0,
  output logic             VAL1
);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_cnt;
  logic                  w_busy;
  logic                  w_wr_acc;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  logic [AW-1:0]         w_rda [2];
  logic [1:0]            w_ren;
  logic [1:0][WIDTH-1:0] w_nq;
  logic [1:0]            w_nv;
  logic [1:0][WIDTH-1:0] r_q;
  logic [1:0]            r_v;

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_SWEEP) ? r_cnt + AW'(1) : '0;
    end
  end

  // CLR is only looked at in IDLE, so a pulse mid-sweep can neither restart nor extend it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (CLR) w_state_nxt = S_SWEEP;
      S_SWEEP: if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state == S_SWEEP) w_busy = 1'b1;
  end

  assign w_wr_acc = ENW && !w_busy && !((ZERO_R0 != 0) && (WRA == '0));

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
    end else begin
      if (w_wr_acc) begin
        r_mem[WRA]   <= D;
        r_valid[WRA] <= 1'b1;
      end
      if (w_busy) begin
        r_mem[r_cnt]   <= '0;
        r_valid[r_cnt] <= 1'b0;
      end
    end
  end

  assign w_rda[0] = RDA0;
  assign w_rda[1] = RDA1;
  assign w_ren    = {ENR1, ENR0};

  always_comb begin
    w_nq = '0;
    w_nv = '0;
    for (int p = 0; p < 2; p++) begin
      w_nq[p] = r_mem[w_rda[p]];
      w_nv[p] = r_valid[w_rda[p]];
      if ((BYPASS != 0) && w_wr_acc && (WRA == w_rda[p])) begin
        w_nq[p] = D;
        w_nv[p] = 1'b1;
      end
      if ((ZERO_R0 != 0) && (w_rda[p] == '0)) begin
        w_nq[p] = '0;
        w_nv[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_q <= '0;
      r_v <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_ren[p]) begin
          r_q[p] <= w_nq[p];
          r_v[p] <= w_nv[p];
        end
      end
    end
  end

  assign BUSY = w_busy;
  assign Q0   = r_q[0];
  assign Q1   = r_q[1];
  assign VAL0 = r_v[0];
  assign VAL1 = r_v[1];

endmodule

// File: tb/tb_reg_file_np.sv
// tb/tb_reg_file_np.sv - bench for reg_file_np: two configurations driven by one stimulus stream
// Instance a: 10x8, bypass, no zero-R0. Instance b: 16x16, no bypass, zero-R0.
module tb_reg_file_np;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] d;
  logic        enw;
  logic [3:0]  wra;
  logic        enr0;
  logic [3:0]  rda0;
  logic        enr1;
  logic [3:0]  rda1;
  logic        clr;

  logic        a_busy, a_v0, a_v1;
  logic [9:0]  a_q0, a_q1;
  logic        b_busy, b_v0, b_v1;
  logic [15:0] b_q0, b_q1;

  reg_file_np #(.WIDTH(10), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) u_a (
    .CLKb(clk), .RSTb(rst_n), .D(d[9:0]), .ENW(enw), .WRA(wra[2:0]),
    .ENR0(enr0), .RDA0(rda0[2:0]), .ENR1(enr1), .RDA1(rda1[2:0]), .CLR(clr),
    .BUSY(a_busy), .Q0(a_q0), .Q1(a_q1), .VAL0(a_v0), .VAL1(a_v1)
  );

  reg_file_np #(.WIDTH(16), .DEPTH(16), .BYPASS(0), .ZERO_R0(1)) u_b (
    .CLKb(clk), .RSTb(rst_n), .D(d), .ENW(enw), .WRA(wra),
    .ENR0(enr0), .RDA0(rda0), .ENR1(enr1), .RDA1(rda1), .CLR(clr),
    .BUSY(b_busy), .Q0(b_q0), .Q1(b_q1), .VAL0(b_v0), .VAL1(b_v1)
  );

  int          depth_k  [2] = '{8, 16};
  int          bypass_k [2] = '{1, 0};
  int          z0_k     [2] = '{0, 1};
  logic [15:0] dmask_k  [2] = '{16'h03FF, 16'hFFFF};

  logic [15:0] m  [2][16];
  bit          mv [2][16];
  logic [15:0] eq [2][2];
  bit          ev [2][2];
  int          busy_rem [2];
  int          sidx [2];

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m[k][i]  = '0;
        mv[k][i] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        eq[k][p] = '0;
        ev[k][p] = 1'b0;
      end
      busy_rem[k] = 0;
      sidx[k]     = 0;
    end
  endtask

  task automatic model_step(input int k);
    int          wa;
    int          ra [2];
    bit          en [2];
    logic [15:0] dd;
    bit          busy, wacc;
    wa    = int'(wra) % depth_k[k];
    ra[0] = int'(rda0) % depth_k[k];
    ra[1] = int'(rda1) % depth_k[k];
    en[0] = enr0;
    en[1] = enr1;
    dd    = d & dmask_k[k];
    busy  = busy_rem[k] > 0;
    wacc  = enw && !busy && !(z0_k[k] == 1 && wa == 0);
    for (int p = 0; p < 2; p++) begin
      if (en[p]) begin
        if (z0_k[k] == 1 && ra[p] == 0) begin
          eq[k][p] = '0;
          ev[k][p] = 1'b1;
        end else if (bypass_k[k] == 1 && wacc && wa == ra[p]) begin
          eq[k][p] = dd;
          ev[k][p] = 1'b1;
        end else begin
          eq[k][p] = m[k][ra[p]];
          ev[k][p] = mv[k][ra[p]];
        end
      end
    end
    if (wacc) begin
      m[k][wa]  = dd;
      mv[k][wa] = 1'b1;
    end
    if (busy) begin
      m[k][sidx[k]]  = '0;
      mv[k][sidx[k]] = 1'b0;
      sidx[k]++;
      busy_rem[k]--;
    end else if (clr) begin
      busy_rem[k] = depth_k[k];
      sidx[k]     = 0;
    end
  endtask

  task automatic idle();
    enw = 0; enr0 = 0; enr1 = 0; clr = 0;
    d = '0; wra = '0; rda0 = '0; rda1 = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] v);
    idle();
    enw = 1; wra = a; d = v;
    cyc();
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    idle();
    enr0 = 1; rda0 = a0; enr1 = 1; rda1 = a1;
    cyc();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("a_busy", 16'(a_busy), 16'(busy_rem[0] > 0));
        chk("a_q0",   16'(a_q0),   eq[0][0]);
        chk("a_v0",   16'(a_v0),   16'(ev[0][0]));
        chk("a_q1",   16'(a_q1),   eq[0][1]);
        chk("a_v1",   16'(a_v1),   16'(ev[0][1]));
        chk("b_busy", 16'(b_busy), 16'(busy_rem[1] > 0));
        chk("b_q0",   b_q0,        eq[1][0]);
        chk("b_v0",   16'(b_v0),   16'(ev[1][0]));
        chk("b_q1",   b_q1,        eq[1][1]);
        chk("b_v1",   16'(b_v1),   16'(ev[1][1]));
      end
    end
  end

  initial begin
    int na, nb;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_a_q0", 16'(a_q0), 16'h0000);
    chk("reset_b_busy", 16'(b_busy), 16'h0000);
    rst_n = 1'b1;

    wr(4'd3, 16'h02A5);
    rd(4'd3, 4'd5);
    chk("wr_rd_a_q0", 16'(a_q0), 16'h02A5);
    chk("wr_rd_a_v0", 16'(a_v0), 16'h0001);
    chk("rd_unwritten_a_q1", 16'(a_q1), 16'h0000);
    chk("rd_unwritten_a_v1", 16'(a_v1), 16'h0000);

    wr(4'd6, 16'h00F0);
    idle();
    enw = 1; wra = 4'd6; d = 16'h0155; enr1 = 1; rda1 = 4'd6;
    cyc();
    chk("bypass_on_a_q1", 16'(a_q1), 16'h0155);
    chk("bypass_off_b_q1", b_q1, 16'h00F0);
    rd(4'd6, 4'd6);
    chk("bypass_off_next_b_q1", b_q1, 16'h0155);

    for (int i = 0; i < 8; i++) wr(4'(i), 16'h0200 | 16'(i));
    idle();
    clr = 1;
    cyc();
    na = 0;
    nb = 0;
    for (int c = 1; c <= 20; c++) begin
      idle();
      if (c == 3) begin enr0 = 1; rda0 = 4'd7; enr1 = 1; rda1 = 4'd0; end
      if (c == 4) begin enw = 1; wra = 4'd2; d = 16'h0333; end
      if (c == 5) clr = 1;
      if (a_busy) na++;
      if (b_busy) nb++;
      cyc();
      if (c == 3) begin
        chk("sweep_old_a_q0", 16'(a_q0), 16'h0207);
        chk("sweep_old_a_v0", 16'(a_v0), 16'h0001);
        chk("sweep_cleared_a_q1", 16'(a_q1), 16'h0000);
        chk("sweep_cleared_a_v1", 16'(a_v1), 16'h0000);
      end
    end
    chk("busy_cycles_a", 16'(na), 16'd8);
    chk("busy_cycles_b", 16'(nb), 16'd16);
    for (int i = 0; i < 8; i++) begin
      rd(4'(i), 4'(i));
      chk("after_sweep_a_q0", 16'(a_q0), 16'h0000);
      chk("after_sweep_a_v0", 16'(a_v0), 16'h0000);
    end

    idle();
    clr = 1; enw = 1; wra = 4'd1; d = 16'h03FF;
    cyc();
    rd(4'd1, 4'd1);
    chk("clr_wr_lands_a_q0", 16'(a_q0), 16'h03FF);
    chk("clr_wr_lands_a_v0", 16'(a_v0), 16'h0001);
    idle();
    repeat (20) cyc();
    rd(4'd1, 4'd1);
    chk("clr_wr_cleared_a_q0", 16'(a_q0), 16'h0000);
    chk("clr_wr_cleared_a_v0", 16'(a_v0), 16'h0000);

    wr(4'd0, 16'hBEEF);
    rd(4'd0, 4'd0);
    chk("z0_b_q0", b_q0, 16'h0000);
    chk("z0_b_v0", 16'(b_v0), 16'h0001);
    wr(4'd15, 16'hBEEF);
    rd(4'd15, 4'd15);
    chk("r15_b_q0", b_q0, 16'hBEEF);
    chk("r15_b_q1", b_q1, 16'hBEEF);

    wr(4'd4, 16'h0123);
    idle();
    clr = 1;
    cyc();
    rd(4'd4, 4'd4);
    idle();
    cyc();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_a_busy", 16'(a_busy), 16'h0000);
    chk("async_rst_a_q0", 16'(a_q0), 16'h0000);
    chk("async_rst_b_q1", b_q1, 16'h0000);
    cyc();
    rst_n = 1'b1;
    wr(4'd5, 16'h0055);
    idle();
    repeat (10) cyc();
    rd(4'd5, 4'd4);
    chk("post_rst_kept_a_q0", 16'(a_q0), 16'h0055);
    chk("post_rst_cleared_a_q1", 16'(a_q1), 16'h0000);
    chk("post_rst_cleared_a_v1", 16'(a_v1), 16'h0000);

    for (int n = 0; n < 1500; n++) begin
      enw  = ($urandom_range(0, 1) == 1);
      wra  = 4'($urandom_range(0, 15));
      d    = 16'($urandom);
      enr0 = ($urandom_range(0, 4) < 3);
      rda0 = 4'($urandom_range(0, 15));
      enr1 = ($urandom_range(0, 4) < 3);
      rda1 = 4'($urandom_range(0, 15));
      clr  = ($urandom_range(0, 49) == 0);
      cyc();
    end

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
